// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared types and defaults for the prefetching instruction fetch buffer.
package armleg_fetch_pkg;

  typedef enum logic {
    FETCH,
    DISCARD
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W  = 64;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam int unsigned PC_INCR     = 4;

endpackage

// File: rtl/instruction_fetch_buffer_if.sv
// Fetch-unit bus: instruction memory req/ack, branch redirect, IF/ID valid/ready.
interface instruction_fetch_buffer_if
  import armleg_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               fetch_ready;
  logic               fetch_valid;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] fetch_instr;

  modport master (
    output imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, fetch_ready
  );

  modport slave (
    input  imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, fetch_ready
  );
endinterface

// File: rtl/instruction_fetch_buffer_fetch_queue.sv
// Circular FIFO of {pc, instr} with flush and a registered head that holds when empty.
module fetch_queue
  import armleg_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   next_count,
  output logic                     head_valid,
  output logic [ADDR_W-1:0]        head_pc,
  output logic [INSTR_W-1:0]       head_instr
);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_q, head_n, push_e;
  logic [PW-1:0]   rd_q, wr_q, rd_n, wr_n;
  logic [PW:0]     cnt_q, cnt_n;

  assign push_e.pc    = push_pc;
  assign push_e.instr = push_instr;

  // Head is a register: it loads the entry that will be at the front after
  // this edge (bypassing the push when the queue drains to it) and holds otherwise.
  always_comb begin
    rd_n   = rd_q;
    wr_n   = wr_q;
    cnt_n  = cnt_q;
    head_n = head_q;
    if (flush) begin
      rd_n  = '0;
      wr_n  = '0;
      cnt_n = '0;
    end else begin
      if (push) wr_n = wr_q + PW'(1);
      if (pop)  rd_n = rd_q + PW'(1);
      cnt_n = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (push && cnt_q == (PW+1)'(pop)) head_n = push_e;
      else if (pop && cnt_n != '0)       head_n = mem[rd_n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      cnt_q  <= cnt_n;
      head_q <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= push_e;
  end

  assign count      = cnt_q;
  assign next_count = cnt_n;
  assign head_valid = (cnt_q != '0);
  assign head_pc    = head_q.pc;
  assign head_instr = head_q.instr;

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Prefetching fetch unit: sequential imem requests, {pc,instr} queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect/discard counters.
module instruction_fetch_buffer
  import armleg_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic CLOCK,
  input  logic RESET,
  instruction_fetch_buffer_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_discards
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_n;
  logic               req_q, req_n;
  logic [ADDR_W-1:0]  addr_q, addr_n, npc_q, npc_n;
  logic               done, push, pop, flush;
  logic [CW-1:0]      count, next_count;

  assign done  = req_q & bus.imem_ack;
  assign flush = bus.redirect_valid;
  assign push  = done & (state_q == FETCH) & ~bus.redirect_valid;
  assign pop   = (count != '0) & bus.fetch_ready & ~bus.redirect_valid;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk        (CLOCK),
    .rst        (RESET),
    .push       (push),
    .push_pc    (addr_q),
    .push_instr (bus.imem_rdata),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .next_count (next_count),
    .head_valid (bus.fetch_valid),
    .head_pc    (bus.fetch_pc),
    .head_instr (bus.fetch_instr)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      npc_q   <= RESET_PC;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      npc_q   <= npc_n;
    end
  end

  // Issuing only when next_count < DEPTH reserves a slot for the outstanding request.
  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    addr_n  = addr_q;
    npc_n   = npc_q;
    unique case (state_q)
      FETCH: begin
        if (bus.redirect_valid) begin
          npc_n = bus.redirect_pc;
          if (req_q && !bus.imem_ack) begin
            state_n = DISCARD;
          end else begin
            req_n  = 1'b1;
            addr_n = bus.redirect_pc;
          end
        end else begin
          if (done) npc_n = npc_q + ADDR_W'(PC_INCR);
          if (!req_q || bus.imem_ack) begin
            req_n  = (next_count < CW'(DEPTH));
            addr_n = npc_n;
          end
        end
      end
      DISCARD: begin
        // A redirect here only retargets npc; the ack still ends the discard.
        if (bus.redirect_valid) npc_n = bus.redirect_pc;
        if (bus.imem_ack) begin
          state_n = FETCH;
          req_n   = 1'b1;
          addr_n  = npc_n;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;

`ifdef FETCH_PERF_CNT_EN
  logic stall, drop;
  assign stall = bus.fetch_valid & ~bus.fetch_ready;
  assign drop  = done & ((state_q == DISCARD) | bus.redirect_valid);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
      perf_discards     <= '0;
    end else begin
      if (stall && perf_stall_cycles != '1)            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bus.redirect_valid && perf_redirects != '1) perf_redirects    <= perf_redirects + 32'd1;
      if (drop && perf_discards != '1)                 perf_discards     <= perf_discards + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Scoreboard bench for instruction_fetch_buffer: directed phases, variable-latency memory model.
module tb_instruction_fetch_buffer;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_buffer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects, perf_discards;
`endif

  instruction_fetch_buffer #(
    .DEPTH    (4),
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (64'h0)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects),
    .perf_discards     (perf_discards)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat    = 0;
  int   wcnt   = 0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  task automatic expect_pc(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: acks after 'lat' wait cycles; reacts on the falling edge.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_rdata = instr_of(bus.imem_addr);
      if (!bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= lat) begin
        bus.imem_ack = 1'b1;
        wcnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: every accepted output is compared against the scoreboard front.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.fetch_valid && bus.fetch_ready && !bus.redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got pc 0x%0h expected no entry", bus.fetch_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.fetch_pc !== e.pc || bus.fetch_instr !== e.instr) begin
            errors++;
            $display("FAIL pop_entry: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                     bus.fetch_pc, bus.fetch_instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.fetch_ready    = 1'b1;

    // Phase 1: reset values, streaming with ack every cycle
    step(2);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_addr", bus.imem_addr, 64'h0);
    check("rst_valid", 64'(bus.fetch_valid), 64'd0);
    check("rst_pc", bus.fetch_pc, 64'h0);
    check("rst_instr", 64'(bus.fetch_instr), 64'h0);
    for (int i = 0; i < 6; i++) expect_pc(64'(4 * i));
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("p1_req", 64'(bus.imem_req), 64'd1);
      check("p1_addr", bus.imem_addr, 64'(4 * (k - 1)));
      if (k == 1) check("p1_valid_c1", 64'(bus.fetch_valid), 64'd0);
      if (k == 2) check("p1_valid_c2", 64'(bus.fetch_valid), 64'd1);
    end
    bus.fetch_ready = 1'b0;
    rst = 1'b1;

    // Phase 2: stall fills the queue, then drains in order
    lat = 0;
    step(2);
    expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8); expect_pc(64'hC);
    rst = 1'b0;
    step(5);
    check("p2_full_req", 64'(bus.imem_req), 64'd0);
    check("p2_full_addr", bus.imem_addr, 64'h10);
    step(5);
    check("p2_stall_req", 64'(bus.imem_req), 64'd0);
    check("p2_stall_valid", 64'(bus.fetch_valid), 64'd1);
    check("p2_stall_pc", bus.fetch_pc, 64'h0);
    bus.fetch_ready = 1'b1;
    step(1);
    check("p2_resume_req", 64'(bus.imem_req), 64'd1);
    check("p2_resume_addr", bus.imem_addr, 64'h10);
    step(3);
    bus.fetch_ready = 1'b0;
    rst = 1'b1;

    // Phase 3: slow memory, redirect while outstanding -> discard
    lat = 3;
    bus.fetch_ready = 1'b1;
    step(2);
    expect_pc(64'h100);
    rst = 1'b0;
    step(1);
    check("p3_req0", bus.imem_addr, 64'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h10;
    step(1);
    bus.redirect_valid = 1'b0;
    check("p3_disc_req", 64'(bus.imem_req), 64'd1);
    check("p3_disc_addr", bus.imem_addr, 64'h0);
    step(3);
    check("p3_addr_10", bus.imem_addr, 64'h10);
    check("p3_drop0_valid", 64'(bus.fetch_valid), 64'd0);
    step(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    step(1);
    bus.redirect_valid = 1'b0;
    check("p3_hold_addr", bus.imem_addr, 64'h10);
    check("p3_hold_req", 64'(bus.imem_req), 64'd1);
    step(2);
    check("p3_addr_100", bus.imem_addr, 64'h100);
    check("p3_drop10_valid", 64'(bus.fetch_valid), 64'd0);
    step(4);
    check("p3_first_valid", 64'(bus.fetch_valid), 64'd1);
    step(1);
    bus.fetch_ready = 1'b0;
    rst = 1'b1;

    // Phase 4: redirect coincides with ack and pop
    lat = 0;
    bus.fetch_ready = 1'b1;
    step(2);
    expect_pc(64'h0); expect_pc(64'h200);
    rst = 1'b0;
    step(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h200;
    step(1);
    bus.redirect_valid = 1'b0;
    check("p4_flush_valid", 64'(bus.fetch_valid), 64'd0);
    check("p4_redir_addr", bus.imem_addr, 64'h200);
    check("p4_redir_req", 64'(bus.imem_req), 64'd1);
    step(2);
    bus.fetch_ready = 1'b0;
    rst = 1'b1;

    // Phase 5: asynchronous reset with two entries queued
    lat = 0;
    step(2);
    rst = 1'b0;
    step(3);
    check("p5_pre_valid", 64'(bus.fetch_valid), 64'd1);
    check("p5_pre_instr", 64'(bus.fetch_instr), 64'(instr_of(64'h0)));
    #2;
    rst = 1'b1;
    #1;
    check("p5_async_req", 64'(bus.imem_req), 64'd0);
    check("p5_async_addr", bus.imem_addr, 64'h0);
    check("p5_async_valid", 64'(bus.fetch_valid), 64'd0);
    check("p5_async_pc", bus.fetch_pc, 64'h0);
    check("p5_async_instr", 64'(bus.fetch_instr), 64'h0);
    expect_pc(64'h0);
    bus.fetch_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check("p5_restart_req", 64'(bus.imem_req), 64'd1);
    check("p5_restart_addr", bus.imem_addr, 64'h0);
    step(2);
    bus.fetch_ready = 1'b0;
    rst = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    // Phase 6: one discard, five stall cycles, two redirects
    lat = 3;
    step(2);
    rst = 1'b0;
    step(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h40;
    step(1);
    bus.redirect_valid = 1'b0;
    step(3);
    lat = 0;
    step(6);
    bus.fetch_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h80;
    step(1);
    bus.redirect_valid = 1'b0;
    bus.fetch_ready    = 1'b0;
    check("perf_stall", 64'(perf_stall_cycles), 64'd5);
    check("perf_redirects", 64'(perf_redirects), 64'd2);
    check("perf_discards", 64'(perf_discards), 64'd1);
    rst = 1'b1;
`endif

    step(2);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
